// File: rtl/rx_bit_timing_ctrl.sv
// Receive bit-timing sequencer: recovers bit phase from bus edges, issues one sample
// strobe per bit and counts accepted (non-stuffed) data bits per byte.
module rx_bit_timing_ctrl #(
    parameter int unsigned CLKS_PER_BIT  = 8,
    parameter int unsigned SAMPLE_PHASE  = 3,
    parameter int unsigned BITS_PER_BYTE = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rcving,
    input  logic       d_edge,
    input  logic       stuff_bit,
    output logic       shift_enable,
    output logic       stuff_skip,
    output logic       byte_received,
    output logic       partial_byte,
    output logic [3:0] bit_cnt
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CntOne    = CW'(1);
    localparam logic [CW-1:0] CntSample = CW'(SAMPLE_PHASE);
    localparam logic [CW-1:0] CntLast   = CW'(CLKS_PER_BIT);
    localparam logic [3:0]    BitsFull  = 4'(BITS_PER_BYTE);
    localparam logic [3:0]    BitsLast  = 4'(BITS_PER_BYTE - 1);

    typedef enum logic [1:0] {StIdle, StSync, StRun} state_e;

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic          r_byte_received, w_byte_received_nxt;
    logic          r_partial_byte, w_partial_byte_nxt;
    logic          w_sample;

    // rcving gates the strobe so an abort never shifts a bit on its way out.
    assign w_sample      = (r_state == StRun) && rcving && (r_clk_cnt == CntSample);
    assign shift_enable  = w_sample && !stuff_bit;
    assign stuff_skip    = w_sample && stuff_bit;
    assign byte_received = r_byte_received;
    assign partial_byte  = r_partial_byte;
    assign bit_cnt       = r_bit_cnt;

    always_comb begin
        w_state_nxt         = r_state;
        w_clk_cnt_nxt       = r_clk_cnt;
        w_bit_cnt_nxt       = r_bit_cnt;
        w_byte_received_nxt = 1'b0;
        w_partial_byte_nxt  = 1'b0;
        case (r_state)
            StIdle: begin
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
                if (rcving) begin
                    w_state_nxt = StSync;
                end
            end
            StSync: begin
                w_clk_cnt_nxt = '0;
                if (!rcving) begin
                    w_state_nxt = StIdle;
                end else if (d_edge) begin
                    w_clk_cnt_nxt = CntOne;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = StRun;
                end
            end
            StRun: begin
                if (!rcving) begin
                    w_state_nxt        = StIdle;
                    w_clk_cnt_nxt      = '0;
                    w_bit_cnt_nxt      = '0;
                    w_partial_byte_nxt = (r_bit_cnt != '0) && (r_bit_cnt != BitsFull);
                end else begin
                    if (d_edge || (r_clk_cnt == CntLast)) begin
                        w_clk_cnt_nxt = CntOne;
                    end else begin
                        w_clk_cnt_nxt = r_clk_cnt + CntOne;
                    end
                    if (shift_enable) begin
                        // A full count means the previous byte was already reported.
                        w_bit_cnt_nxt       = (r_bit_cnt == BitsFull) ? 4'd1 : r_bit_cnt + 4'd1;
                        w_byte_received_nxt = (r_bit_cnt == BitsLast);
                    end
                end
            end
            default: begin
                w_state_nxt   = StIdle;
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= StIdle;
            r_clk_cnt       <= '0;
            r_bit_cnt       <= '0;
            r_byte_received <= 1'b0;
            r_partial_byte  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_clk_cnt       <= w_clk_cnt_nxt;
            r_bit_cnt       <= w_bit_cnt_nxt;
            r_byte_received <= w_byte_received_nxt;
            r_partial_byte  <= w_partial_byte_nxt;
        end
    end

endmodule

// File: doc/rx_bit_timing_ctrl.md
Name: rx_bit_timing_ctrl

Overview:
- Sequences bit timing for the serial receive path.
- Recovers bit phase from bus edges and produces a one-cycle sample strobe per bit.
- Counts data bits per byte, excluding stuffed bits, and flags byte completion and aborted partial bytes.
- Sits between the edge detector / stuff detector and the receive shift register / receive control FSM.

Parameters:
- CLKS_PER_BIT, default 8: system clocks per serial bit period; legal range is 2 or more.
- SAMPLE_PHASE, default 3: clock-counter value at which the bit is sampled; legal range is 1..CLKS_PER_BIT.
- BITS_PER_BYTE, default 8: accepted data bits per byte; legal range is 2..15.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  reset, asynchronous, active-low
- rcving  input  1  packet reception in progress; low aborts and returns to IDLE
- d_edge  input  1  one-cycle pulse on any bus transition (phase resync)
- stuff_bit  input  1  current bit is a stuffed bit; qualified only on the sample cycle
- shift_enable  output  1  one-cycle pulse: shift the current data bit (never asserted for stuffed bits)
- stuff_skip  output  1  one-cycle pulse: sample cycle that was dropped as stuffed
- byte_received  output  1  registered one-cycle pulse: BITS_PER_BYTE bits accepted
- partial_byte  output  1  registered one-cycle pulse: reception aborted mid-byte
- bit_cnt  output  4  accepted bits in the current byte (0..BITS_PER_BYTE)

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (n_rst). Clock port is clk.
- Reset values: state=IDLE, clk_cnt=0, bit_cnt=0, byte_received=0, partial_byte=0.
- Internal clk_cnt has width $clog2(CLKS_PER_BIT+1).
- The sample condition is: state==RUN, rcving==1, clk_cnt==SAMPLE_PHASE.
- shift_enable = sample condition AND !stuff_bit. This is combinational from registered state.
- stuff_skip = sample condition AND stuff_bit.
- FSM states: IDLE, SYNC, RUN.
- IDLE:
  - clk_cnt=0, bit_cnt=0.
  - rcving=1 goes to SYNC next cycle.
- SYNC:
  - Waits for phase. clk_cnt is held at 0.
  - d_edge=1 with rcving=1 sets clk_cnt=1, bit_cnt=0 and goes to RUN.
  - rcving=0 goes to IDLE.
- RUN, clock counter priority:
  - rcving=0 goes to IDLE.
  - Otherwise, d_edge sets clk_cnt=1 next cycle.
  - Otherwise, clk_cnt==CLKS_PER_BIT wraps to 1.
  - Otherwise, clk_cnt+1.
- RUN, bit counter:
  - On shift_enable: if bit_cnt==BITS_PER_BYTE then bit_cnt becomes 1, else bit_cnt+1.
  - On stuff_skip: bit_cnt unchanged.
- byte_received is asserted the cycle after a shift_enable that brings bit_cnt to BITS_PER_BYTE. It lasts one cycle.
- Abort: rcving low while in RUN with bit_cnt not in {0, BITS_PER_BYTE}:
  - partial_byte pulses the next cycle.
  - State goes to IDLE and bit_cnt goes to 0.
- rcving low on a cycle where the sample condition would hold:
  - No shift_enable or stuff_skip is generated (rcving gates the strobe).
  - byte_received is not generated.
- d_edge coincident with the sample condition:
  - The strobe still fires that cycle.
  - clk_cnt reloads to 1 on the next cycle.
- d_edge in IDLE is ignored.
- Reset asserted mid-byte forces all reset values immediately.
- partial_byte and byte_received are never asserted in the same cycle.

Test Plan:
- Assert and release n_rst with rcving=0 and d_edge pulses -> all outputs 0, bit_cnt=0, no strobes.
- Defaults; rcving=1 at t=0; d_edge at t=2; no further edges -> shift_enable at t=5, 13, 21, …, 61 (8 pulses); bit_cnt reads 8 after t=61; byte_received high only at t=62.
- Same as previous, but stuff_bit=1 on the 4th sample (t=29) -> stuff_skip at t=29; shift_enable absent at t=29; bit_cnt holds 3; 8th shift_enable at t=69; byte_received at t=70.
- In RUN, d_edge when clk_cnt=5 -> clk_cnt=1 next cycle; next shift_enable exactly 2 cycles after that.
- d_edge coincident with clk_cnt=3 -> shift_enable fires that cycle; clk_cnt=1 next cycle; following strobe 3 cycles after the edge.
- rcving drops after 5 accepted bits -> partial_byte for one cycle, state IDLE, bit_cnt=0, no byte_received. Drop after exactly 8 bits -> no partial_byte.
